// File: rtl/aes128_ctrl_pkg.sv
// Shared types and defaults for the AES128 decrypt request arbiter.
package aes128_ctrl_pkg;

    localparam int unsigned DATA_W             = 128;
    localparam int unsigned NUM_REQ            = 2;
    localparam int unsigned DEFAULT_TIMEOUT    = 64;
    localparam int unsigned DEFAULT_GAP_CYCLES = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

endpackage

// File: rtl/aes128_decrypt_arbiter_if.sv
// Requester handshake plus shared-core connection for the decrypt arbiter.
interface aes128_decrypt_arbiter_if;
    import aes128_ctrl_pkg::*;

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_in;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_key;
    logic [NUM_REQ-1:0]             resp_valid;
    logic [DATA_W-1:0]              resp_data;
    logic                           resp_err;
    logic                           core_start;
    logic [DATA_W-1:0]              core_in;
    logic [DATA_W-1:0]              core_key;
    logic                           core_finish;
    logic [DATA_W-1:0]              core_result;

    // Arbiter side
    modport slave (
        input  req_valid, req_in, req_key, core_finish, core_result,
        output req_ready, resp_valid, resp_data, resp_err, core_start, core_in, core_key
    );

    // Requesters plus core side
    modport master (
        output req_valid, req_in, req_key, core_finish, core_result,
        input  req_ready, resp_valid, resp_data, resp_err, core_start, core_in, core_key
    );

endinterface

// File: rtl/aes_rr_arb2.sv
// Two-way round-robin picker; the last-served requester loses ties.
module aes_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] grant,
    output logic       win_idx
);

    // Index served last; reset to 1 so requester 0 wins the first tie.
    logic last;

    // Winner selection from current requests and history
    always_comb begin
        win_idx = 1'b0;
        if (req == 2'b11) begin
            win_idx = ~last;
        end else if (req == 2'b10) begin
            win_idx = 1'b1;
        end
        grant = 2'b00;
        if (req != 2'b00) begin
            grant = win_idx ? 2'b10 : 2'b01;
        end
    end

    // History update when the winner is actually taken
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (take) begin
            last <= win_idx;
        end
    end

endmodule

// File: rtl/aes128_decrypt_arbiter.sv
// Shares one external AES128 decrypt core between two requesters:
// grant, run the core with a timeout, pulse the response, then hold
// core_start low for a minimum gap before the next operation.
module aes128_decrypt_arbiter
    import aes128_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT,
    parameter int unsigned GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
    input logic                     clk,
    input logic                     rst,
    aes128_decrypt_arbiter_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam int unsigned GAP_W = 4;
    // The IDLE grant cycle is itself a core_start-low cycle, so the GAP
    // state covers the remaining GAP_CYCLES-1 cycles of the low window.
    localparam int unsigned GAP_LAST = (GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0;

    state_t             state;
    logic [CNT_W-1:0]   run_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [NUM_REQ-1:0] owner;
    logic [NUM_REQ-1:0] grant;
    logic               win_idx;
    logic               take;

    // req_ready must coincide with the capture edge, so it is decoded
    // from the registered state rather than registered itself.
    assign take          = !rst && (state == ST_IDLE) && (bus.req_valid != '0);
    assign bus.req_ready = take ? grant : '0;

    aes_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req_valid),
        .take    (take),
        .grant   (grant),
        .win_idx (win_idx)
    );

    // Control FSM with registered core and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            run_cnt        <= '0;
            gap_cnt        <= '0;
            owner          <= '0;
            bus.core_start <= 1'b0;
            bus.core_in    <= '0;
            bus.core_key   <= '0;
            bus.resp_valid <= '0;
            bus.resp_data  <= '0;
            bus.resp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        owner          <= grant;
                        bus.core_in    <= bus.req_in[win_idx];
                        bus.core_key   <= bus.req_key[win_idx];
                        bus.core_start <= 1'b1;
                        run_cnt        <= '0;
                        state          <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Finish seen in the first RUN cycle may be left over
                    // from the previous operation, so it is not trusted.
                    if ((run_cnt != '0) && bus.core_finish) begin
                        bus.resp_data  <= bus.core_result;
                        bus.resp_err   <= 1'b0;
                        bus.resp_valid <= owner;
                        state          <= ST_RESP;
                    end else if (run_cnt == CNT_W'(TIMEOUT - 1)) begin
                        bus.resp_data  <= '0;
                        bus.resp_err   <= 1'b1;
                        bus.resp_valid <= owner;
                        state          <= ST_RESP;
                    end else begin
                        run_cnt <= run_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    bus.resp_valid <= '0;
                    bus.resp_err   <= 1'b0;
                    bus.core_start <= 1'b0;
                    gap_cnt        <= '0;
                    state          <= (GAP_CYCLES > 1) ? ST_GAP : ST_IDLE;
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_LAST)) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/aes128_decrypt_arbiter.md
AES128_DECRYPT_ARBITER -- requirements
Module: aes128_decrypt_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64: max cycles from core_start rise to core_finish before abort.
REQ-002 Parameter GAP_CYCLES, default 2: cycles core_start is held low between operations; legal range 1..15.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 req_valid  input  2  per-requester request valid; bit i = requester i.
REQ-006 req_ready  output  2  per-requester accept; a transfer occurs when valid and ready are both high.
REQ-007 req_in  input  2x128  per-requester ciphertext.
REQ-008 req_key  input  2x128  per-requester key.
REQ-009 resp_valid  output  2  one-cycle response pulse, bit i for requester i.
REQ-010 resp_data  output  128  plaintext; valid while any resp_valid bit is high.
REQ-011 resp_err  output  1  qualifies resp_valid: 1 = timed out, resp_data = 0.
REQ-012 core_start  output  1  level start to the shared AES128 decrypt core.
REQ-013 core_in  output  128  ciphertext to the core; stable while core_start = 1.
REQ-014 core_key  output  128  key to the core; stable while core_start = 1.
REQ-015 core_finish  input  1  core completion flag.
REQ-016 core_result  input  128  core plaintext output.

Function
REQ-017 FSM states: IDLE, RUN, RESP, GAP.
REQ-018 IDLE: when any req_valid bit is set, the block picks a winner round-robin, asserts req_ready for that bit for exactly one cycle, and captures req_in/req_key into core_in/core_key. It then goes to RUN.
REQ-019 Round-robin: the last-served requester has lowest priority. After reset requester 0 has priority.
REQ-020 Only one req_ready bit is ever high, and only in IDLE.
REQ-021 RUN: core_start = 1 and a cycle counter runs from 0.
REQ-022 RUN: core_finish is ignored in the first RUN cycle, because it may be stale from the previous operation. It is sampled from the second RUN cycle onward.
REQ-023 RUN: a sampled core_finish = 1 registers core_result into resp_data and moves to RESP.
REQ-024 RUN: when the counter reaches TIMEOUT without a sampled finish, resp_data = 0, resp_err = 1, and the FSM goes to RESP.
REQ-025 RESP: resp_valid pulses for exactly one cycle on the granted requester's bit. core_start is held 1 in this cycle. The FSM then goes to GAP.
REQ-026 GAP: core_start = 0 for exactly GAP_CYCLES cycles, then the FSM returns to IDLE.
REQ-027 Latency: grant cycle, plus core cycles, plus 1 for the RESP cycle, plus GAP_CYCLES before the next grant. Back-to-back requests from one requester are therefore never closer than GAP_CYCLES+3 cycles.
REQ-028 If both requesters are valid in IDLE, exactly one is granted. The loser keeps valid high and is served next.
REQ-029 A requester dropping req_valid while not granted has no effect.
REQ-030 req_* changes after the grant do not affect the operation in flight.

Reset
REQ-031 rst forces state IDLE, core_start = 0, req_ready = 0, resp_valid = 0, resp_err = 0, resp_data = 0, core_in = 0, core_key = 0, counters = 0, and priority to requester 0.
REQ-032 rst mid-operation abandons the operation with no response pulse. The core sees core_start = 0 from the next cycle.

Structure
REQ-033 Package aes128_ctrl_pkg holds the FSM state enum and the default TIMEOUT and GAP_CYCLES constants.
REQ-034 Sub-module aes_rr_arb2 holds the 2-way round-robin grant logic. The AES128 decrypt core stays outside the block and connects through the core_* ports.

Verification
REQ-035 Bench: the real AES128 decrypt core on the core_* ports, key 128'h3c4fcf098815f7aba6d2ae2816157e2b, plus a 10 ns clock.
REQ-036 Requester 0 sends 128'h97ef6624f3ca9ea860367a0db47bd73a -> one resp_valid[0] pulse, resp_data = 128'h2a179373117e3de9969f402ee2bec16b, resp_err = 0.
REQ-037 Both requesters valid together, req0 = 128'hafbafd965a8985e79d69b90385d5d3f5, req1 = 128'h880603ede3001b8823ce8e597fcdb143 -> req0 served first with 128'h518eaf45ac6fb79e9cac031e578a2dae, then req1 with 128'hef520a1a19c1fbe511e45ca3461cc830. core_start is low for exactly 2 cycles between the two operations.
REQ-038 Core replaced by a stub that never asserts finish, TIMEOUT = 64 -> resp_valid pulse 64 cycles after core_start rises, resp_err = 1, resp_data = 0.
REQ-039 rst pulsed mid-RUN while processing 128'hd45d7204712023823fade8275e780c7b -> no resp_valid; core_start = 0 on the next cycle; a retry then yields 128'h10376ce67b412bad179b4fdf45249ff6.
REQ-040 Stub core holding finish = 1 at start rise, then asserting finish with result 128'h1 -> the first-cycle finish is ignored and resp_data = 128'h1.
